// File: rtl/pc_pkg.sv
// Shared types and default constants for the fetch-address generator.
package pc_pkg;

  typedef enum logic [1:0] {BOOT, IDLE, REQ} pcf_state_t;

  localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
  localparam int          PC_INC          = 4;
  localparam int          PC_ALIGN_BITS   = 2;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch request channel between the PC generator and the I-cache front end.
interface pc_fetch_unit_if #(
  parameter int WIDTH = 32
);

  logic             req_valid;
  logic [WIDTH-1:0] req_pc;
  logic             req_ready;
  logic             redir_taken;

  modport master (
    output req_valid,
    output req_pc,
    output redir_taken,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_pc,
    input  redir_taken,
    output req_ready
  );

endinterface

// File: rtl/pc_redirect_sel.sv
// Combinational next-PC selection: trap > branch/jump > pending > sequential,
// with low-bit masking of redirect targets and misalignment detection.
module pc_redirect_sel #(
  parameter int WIDTH      = 32,
  parameter int INC        = 4,
  parameter int ALIGN_BITS = 2
) (
  input  logic [WIDTH-1:0] pc,
  input  logic             redir_valid,
  input  logic [WIDTH-1:0] redir_target,
  input  logic             trap_valid,
  input  logic [WIDTH-1:0] trap_target,
  input  logic             pend_valid,
  input  logic [WIDTH-1:0] pend_target,
  output logic             rv,
  output logic [WIDTH-1:0] tgt,
  output logic             misaligned,
  output logic [WIDTH-1:0] accept_pc,
  output logic             accept_redirect
);

  // ALIGN_BITS == 0 yields an all-zero mask, which disables both masking and the check.
  localparam logic [WIDTH-1:0] ONES     = '1;
  localparam logic [WIDTH-1:0] LOW_MASK = ~(ONES << ALIGN_BITS);

  logic [WIDTH-1:0] raw_tgt;
  logic [WIDTH-1:0] seq_pc;

  assign raw_tgt    = trap_valid ? trap_target : redir_target;
  assign rv         = trap_valid | redir_valid;
  assign tgt        = raw_tgt & ~LOW_MASK;
  assign misaligned = rv & (|(raw_tgt & LOW_MASK));

  assign seq_pc = pc + WIDTH'(INC);

  assign accept_pc       = rv ? tgt : (pend_valid ? pend_target : seq_pc);
  assign accept_redirect = rv | pend_valid;

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-address generator: PC register, I-cache request handshake, stall handling
// and buffering of redirects that arrive while a request is outstanding.
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
  parameter int               INC          = PC_INC,
  parameter int               ALIGN_BITS   = PC_ALIGN_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 redir_valid,
  input  logic [WIDTH-1:0]     redir_target,
  input  logic                 trap_valid,
  input  logic [WIDTH-1:0]     trap_target,
  output logic                 misalign_err,
  pc_fetch_unit_if.master      fetch
);

  // state | meaning
  // BOOT  | bubble cycle after reset; redirects load pc silently
  // IDLE  | no request presented (stalled)
  // REQ   | request presented, held until req_ready
  localparam logic [1:0] S_BOOT = BOOT;
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_REQ  = REQ;

  logic [1:0]       state;
  logic [WIDTH-1:0] pc;
  logic             pend_valid;
  logic [WIDTH-1:0] pend_target;
  logic             redir_taken;

  logic             rv;
  logic [WIDTH-1:0] tgt;
  logic             misaligned;
  logic [WIDTH-1:0] accept_pc;
  logic             accept_redirect;

  pc_redirect_sel #(
    .WIDTH      (WIDTH),
    .INC        (INC),
    .ALIGN_BITS (ALIGN_BITS)
  ) u_sel (
    .pc              (pc),
    .redir_valid     (redir_valid),
    .redir_target    (redir_target),
    .trap_valid      (trap_valid),
    .trap_target     (trap_target),
    .pend_valid      (pend_valid),
    .pend_target     (pend_target),
    .rv              (rv),
    .tgt             (tgt),
    .misaligned      (misaligned),
    .accept_pc       (accept_pc),
    .accept_redirect (accept_redirect)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_BOOT;
      pc           <= RESET_VECTOR;
      pend_valid   <= 1'b0;
      pend_target  <= '0;
      redir_taken  <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= misaligned;
      redir_taken  <= 1'b0;
      case (state)
        S_BOOT: begin
          if (rv) pc <= tgt;
          state <= stall ? S_IDLE : S_REQ;
        end
        S_IDLE: begin
          if (rv) begin
            pc          <= tgt;
            redir_taken <= 1'b1;
          end
          state <= stall ? S_IDLE : S_REQ;
        end
        S_REQ: begin
          if (fetch.req_ready) begin
            pc          <= accept_pc;
            redir_taken <= accept_redirect;
            pend_valid  <= 1'b0;
            state       <= stall ? S_IDLE : S_REQ;
          end else if (rv) begin
            // Request must stay stable; park the redirect until the stale fetch is accepted.
            pend_target <= tgt;
            pend_valid  <= 1'b1;
          end
        end
        default: state <= S_BOOT;
      endcase
    end
  end

  assign fetch.req_valid   = (state == S_REQ);
  assign fetch.req_pc      = pc;
  assign fetch.redir_taken = redir_taken;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: accepted fetch addresses go through a
// scoreboard queue; pulse and hold behaviour is checked at fixed cycles.
module tb_pc_fetch_unit;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             stall;
  logic             redir_valid;
  logic [WIDTH-1:0] redir_target;
  logic             trap_valid;
  logic [WIDTH-1:0] trap_target;
  logic             misalign_err;

  pc_fetch_unit_if #(.WIDTH(WIDTH)) fetch ();

  pc_fetch_unit #(
    .WIDTH        (WIDTH),
    .RESET_VECTOR (32'h0000_0000),
    .INC          (4),
    .ALIGN_BITS   (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .trap_valid   (trap_valid),
    .trap_target  (trap_target),
    .misalign_err (misalign_err),
    .fetch        (fetch)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every handshake seen before the next rising edge is an accept.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && fetch.req_valid && fetch.req_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL accept_unexpected: got pc 0x%08h, expected no accept", fetch.req_pc);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          chk("accept_pc", fetch.req_pc, e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0;
    redir_valid = 1'b0; redir_target = '0;
    trap_valid = 1'b0; trap_target = '0;
    fetch.req_ready = 1'b1;

    // 1. reset and boot bubble
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_req_valid", 32'(fetch.req_valid), 0);
    end
    chk("reset_pc", fetch.req_pc, 32'h0);
    rst = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    chk("boot_bubble", 32'(fetch.req_valid), 0);
    step(); step(); step();

    // 2. backpressure at 0x8 with stall pulsed
    fetch.req_ready = 1'b0;
    step();
    chk("bp_valid", 32'(fetch.req_valid), 1); chk("bp_pc", fetch.req_pc, 32'h8);
    stall = 1'b1;
    step();
    chk("bp_valid", 32'(fetch.req_valid), 1); chk("bp_pc", fetch.req_pc, 32'h8);
    step();
    chk("bp_valid", 32'(fetch.req_valid), 1); chk("bp_pc", fetch.req_pc, 32'h8);
    stall = 1'b0;
    step();
    chk("bp_valid", 32'(fetch.req_valid), 1); chk("bp_pc", fetch.req_pc, 32'h8);
    fetch.req_ready = 1'b1;
    exp_q.push_back(32'hC);
    step();
    chk("bp_next_pc", fetch.req_pc, 32'hC);
    step();

    // 3. pending redirect, second one overwrites the first
    fetch.req_ready = 1'b0;
    redir_valid = 1'b1; redir_target = 32'h100;
    step();
    redir_target = 32'h200;
    step();
    redir_valid = 1'b0;
    chk("pend_hold_pc", fetch.req_pc, 32'h10);
    fetch.req_ready = 1'b1;
    exp_q.push_back(32'h10); exp_q.push_back(32'h200);
    step();
    chk("pend_pc", fetch.req_pc, 32'h200);
    chk("pend_taken", 32'(fetch.redir_taken), 1);
    exp_q.push_back(32'h204);
    step();
    chk("taken_pulse_end", 32'(fetch.redir_taken), 0);

    // 4. trap beats branch redirect
    trap_valid = 1'b1; trap_target = 32'h80;
    redir_valid = 1'b1; redir_target = 32'h40;
    step();
    trap_valid = 1'b0; redir_valid = 1'b0;
    chk("prio_pc", fetch.req_pc, 32'h80);
    chk("prio_taken", 32'(fetch.redir_taken), 1);
    exp_q.push_back(32'h80);

    // 5. stall, redirect during stall
    stall = 1'b1;
    step();
    chk("stall_valid", 32'(fetch.req_valid), 0);
    redir_valid = 1'b1; redir_target = 32'h300;
    step();
    redir_valid = 1'b0;
    chk("stall_redir_valid", 32'(fetch.req_valid), 0);
    chk("stall_redir_pc", fetch.req_pc, 32'h300);
    chk("stall_redir_taken", 32'(fetch.redir_taken), 1);
    step();
    chk("stall_valid3", 32'(fetch.req_valid), 0);
    stall = 1'b0;
    exp_q.push_back(32'h300);
    step();
    chk("post_stall_valid", 32'(fetch.req_valid), 1);
    chk("post_stall_pc", fetch.req_pc, 32'h300);

    // 6a. misaligned target is masked and flagged for one cycle
    redir_valid = 1'b1; redir_target = 32'h102;
    step();
    redir_valid = 1'b0;
    chk("misalign_pc", fetch.req_pc, 32'h100);
    chk("misalign_err", 32'(misalign_err), 1);
    exp_q.push_back(32'h100);
    step();
    chk("misalign_clear", 32'(misalign_err), 0);
    chk("after_misalign_pc", fetch.req_pc, 32'h104);

    // 6b. wrap from the top of the address space
    exp_q.push_back(32'h104);
    redir_valid = 1'b1; redir_target = 32'hFFFF_FFFC;
    step();
    redir_valid = 1'b0;
    chk("top_pc", fetch.req_pc, 32'hFFFF_FFFC);
    chk("top_misalign", 32'(misalign_err), 0);
    exp_q.push_back(32'hFFFF_FFFC);
    step();
    chk("wrap_pc", fetch.req_pc, 32'h0);

    // reset mid-handshake drops the outstanding request and the pending redirect
    fetch.req_ready = 1'b0;
    redir_valid = 1'b1; redir_target = 32'h500;
    step();
    redir_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(fetch.req_valid), 0);
    chk("async_rst_pc", fetch.req_pc, 32'h0);
    step();
    rst = 1'b0;
    fetch.req_ready = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    chk("reboot_bubble", 32'(fetch.req_valid), 0);
    step(); step(); step();
    fetch.req_ready = 1'b0;
    chk("reboot_pc", fetch.req_pc, 32'h8);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
